// File: rtl/ir_text_buffer.sv
// Two-line (2x16) character buffer fed by IR key strobes, read by the LCD controller.
// Maps key codes to ASCII, keeps a cursor, and flags the LCD to redraw after each change.
module ir_text_buffer #(
    parameter int HOLDOFF = 2_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key_code,
    input  logic       key_valid,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [4:0] cursor,
    output logic       upd_req,
    input  logic       upd_ack,
    output logic       key_dropped
);

    localparam int HW = $clog2(HOLDOFF + 1);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    state_t          r_state;
    logic [7:0]      r_code;
    logic [4:0]      r_cursor;
    logic [4:0]      r_clrIdx;
    logic [HW-1:0]   r_holdoff;
    logic            r_updReq;
    logic            r_keyDropped;
    logic [7:0]      r_rdChar;
    logic [7:0]      r_mem [0:31];

    logic            w_keyMapped;
    logic            w_isPrint;
    logic            w_isBack;
    logic            w_isClear;
    logic [7:0]      w_ascii;
    logic            w_accept;
    logic            w_drop;
    logic            w_we;
    logic [4:0]      w_waddr;
    logic [7:0]      w_wdata;
    logic            w_setUpd;

    function automatic logic isPrintable(input logic [7:0] c);
        return (c <= 8'd9) || (c == 8'h0F) || (c == 8'h13) || (c == 8'h10);
    endfunction

    assign w_keyMapped = isPrintable(key_code) || (key_code == 8'h14) || (key_code == 8'h15);
    assign w_isPrint   = isPrintable(r_code);
    assign w_isBack    = (r_code == 8'h14);
    assign w_isClear   = (r_code == 8'h15);

    // Unmapped codes are invisible: they are neither accepted nor reported as dropped.
    assign w_accept = (r_state == IDLE) && key_valid && w_keyMapped && (r_holdoff == '0);
    assign w_drop   = key_valid && w_keyMapped && !w_accept;

    always_comb begin
        w_ascii = 8'h20;
        if (r_code <= 8'd9) begin
            w_ascii = 8'h30 + r_code;
        end else if (r_code == 8'h0F) begin
            w_ascii = 8'h41;
        end else if (r_code == 8'h13) begin
            w_ascii = 8'h42;
        end else if (r_code == 8'h10) begin
            w_ascii = 8'h43;
        end
    end

    always_comb begin
        w_we     = 1'b0;
        w_waddr  = r_cursor;
        w_wdata  = 8'h20;
        w_setUpd = 1'b0;
        case (r_state)
            WRITE: begin
                if (w_isPrint) begin
                    w_we     = 1'b1;
                    w_wdata  = w_ascii;
                    w_setUpd = 1'b1;
                end else if (w_isBack && (r_cursor != 5'd0)) begin
                    w_we     = 1'b1;
                    w_waddr  = r_cursor - 5'd1;
                    w_setUpd = 1'b1;
                end
            end
            CLEAR: begin
                w_we     = 1'b1;
                w_waddr  = r_clrIdx;
                w_setUpd = (r_clrIdx == 5'd31);
            end
            default: ;
        endcase
    end

    // Gating with rst_n ensures an operation interrupted by reset never lands in the array.
    always_ff @(posedge clk) begin
        if (rst_n && w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= CLEAR;
            r_code       <= 8'h00;
            r_clrIdx     <= 5'd0;
            r_cursor     <= 5'd0;
            r_holdoff    <= '0;
            r_updReq     <= 1'b0;
            r_keyDropped <= 1'b0;
            r_rdChar     <= 8'h20;
        end else begin
            r_rdChar     <= r_mem[rd_addr];
            r_keyDropped <= w_drop;

            if (w_accept) begin
                r_holdoff <= HW'(HOLDOFF);
            end else if (r_holdoff != '0) begin
                r_holdoff <= r_holdoff - HW'(1);
            end

            // A change completing together with an acknowledge keeps the request pending.
            if (w_setUpd) begin
                r_updReq <= 1'b1;
            end else if (upd_ack && r_updReq) begin
                r_updReq <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_code  <= key_code;
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    r_state <= IDLE;
                    if (w_isPrint) begin
                        r_cursor <= r_cursor + 5'd1;
                    end else if (w_isBack && (r_cursor != 5'd0)) begin
                        r_cursor <= r_cursor - 5'd1;
                    end else if (w_isClear) begin
                        r_clrIdx <= 5'd0;
                        r_state  <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_clrIdx <= r_clrIdx + 5'd1;
                    if (r_clrIdx == 5'd31) begin
                        r_cursor <= 5'd0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_char     = r_rdChar;
    assign cursor      = r_cursor;
    assign upd_req     = r_updReq;
    assign key_dropped = r_keyDropped;

endmodule
